// File: rtl/fsm16_pkg.sv
// Shared definitions for the 16-bit execution core:
// opcodes, ALU state encoding and PC/SP reset constants.
package fsm16_pkg;

    localparam logic [5:0] OP_ADD = 6'h01;
    localparam logic [5:0] OP_SUB = 6'h02;
    localparam logic [5:0] OP_MUL = 6'h03;
    localparam logic [5:0] OP_DIV = 6'h04;
    localparam logic [5:0] OP_MOD = 6'h05;
    localparam logic [5:0] OP_AND = 6'h06;
    localparam logic [5:0] OP_OR  = 6'h07;
    localparam logic [5:0] OP_XOR = 6'h08;
    localparam logic [5:0] OP_NOT = 6'h09;
    localparam logic [5:0] OP_LSL = 6'h0A;
    localparam logic [5:0] OP_LSR = 6'h0B;
    localparam logic [5:0] OP_ROL = 6'h0C;
    localparam logic [5:0] OP_ROR = 6'h0D;
    localparam logic [5:0] OP_CMP = 6'h0E;
    localparam logic [5:0] OP_TST = 6'h0F;
    localparam logic [5:0] OP_INC = 6'h10;
    localparam logic [5:0] OP_DEC = 6'h11;
    localparam logic [5:0] OP_MOV = 6'h12;

    localparam logic [15:0] SP_TOP   = 16'h01FF;
    localparam logic [15:0] PC_RESET = 16'h0000;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        ITER,
        DONE
    } alu_state_e;

    // Opcodes served by the iterative multiplier/divider.
    function automatic logic is_iter_op(input logic [5:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/fsm16_muldiv.sv
// 16-step shift-add multiplier / restoring divider.
// MUL: {hi,lo} = b*a.  DIV: lo = b/a, hi = b%a.
module fsm16_muldiv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        is_mul,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        done,
    output logic [15:0] hi,
    output logic [15:0] lo
);

    logic [15:0] hi_q, hi_d;
    logic [15:0] lo_q, lo_d;
    logic [15:0] dv_q, dv_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        mul_q, mul_d;
    logic [16:0] sum;
    logic [16:0] rsh;
    logic [16:0] diff;

    // One multiply or divide step per cycle while the counter runs.
    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        dv_d  = dv_q;
        cnt_d = cnt_q;
        mul_d = mul_q;
        sum   = {1'b0, hi_q} + {1'b0, dv_q};
        rsh   = {hi_q, lo_q[15]};
        diff  = rsh - {1'b0, dv_q};
        if (load) begin
            hi_d  = 16'h0000;
            lo_d  = b;
            dv_d  = a;
            cnt_d = 5'd16;
            mul_d = is_mul;
        end else if (cnt_q != 5'd0) begin
            cnt_d = cnt_q - 5'd1;
            if (mul_q) begin
                if (lo_q[0]) begin
                    {hi_d, lo_d} = {sum, lo_q[15:1]};
                end else begin
                    {hi_d, lo_d} = {1'b0, hi_q, lo_q[15:1]};
                end
            end else if (!diff[16]) begin
                hi_d = diff[15:0];
                lo_d = {lo_q[14:0], 1'b1};
            end else begin
                hi_d = rsh[15:0];
                lo_d = {lo_q[14:0], 1'b0};
            end
        end
    end

    // Step registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q  <= 16'h0000;
            lo_q  <= 16'h0000;
            dv_q  <= 16'h0000;
            cnt_q <= 5'd0;
            mul_q <= 1'b0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            dv_q  <= dv_d;
            cnt_q <= cnt_d;
            mul_q <= mul_d;
        end
    end

    assign done = (cnt_q == 5'd0);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/fsm_16bit_exec.sv
// Execution core: multi-cycle ALU FSM, program counter
// and downward-growing stack pointer.
module fsm_16bit_exec #(
    parameter logic [15:0] SP_TOP   = fsm16_pkg::SP_TOP,
    parameter logic [15:0] PC_RESET = fsm16_pkg::PC_RESET
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mov_enable,
    input  logic [5:0]  op_code,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        bin,
    input  logic        cin,
    output logic [15:0] result,
    output logic [15:0] remainder,
    output logic        bout,
    output logic        cout,
    output logic        busy,
    output logic        overflow_flag,
    output logic        carry_flag,
    output logic        negative_flag,
    output logic        zero_flag,
    input  logic        save_address_from_instr_mem,
    input  logic        save_address_from_data_mem,
    input  logic        save_address_from_counter,
    input  logic        increm_pc,
    input  logic [15:0] address_from_instr_mem,
    input  logic [15:0] address_from_data_mem,
    input  logic [15:0] address_from_counter_pc,
    output logic [15:0] pc_out,
    input  logic        push,
    input  logic        pop,
    output logic [15:0] sp_out
);

    import fsm16_pkg::*;

    alu_state_e  state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic        cin_q, cin_d, bin_q, bin_d;
    logic [15:0] result_q, result_d;
    logic [15:0] rem_q, rem_d;
    logic        bout_q, bout_d, cout_q, cout_d;
    logic        ovf_q, ovf_d, cy_q, cy_d;
    logic        neg_q, neg_d, zro_q, zro_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] sp_q, sp_d;

    logic        md_load, md_done;
    logic [15:0] md_hi, md_lo, md_val;

    logic [3:0]  sh;
    logic [16:0] add_r, sub_r, cmp_r, inc_r, dec_r;
    logic [31:0] lsl_w, lsr_w, rol_w, ror_w;
    logic [15:0] val;
    logic        val_c, val_v;
    logic        wr_res, wr_fl, wr_cout, wr_bout;

    assign md_load = (state_q == IDLE) && start && is_iter_op(op_code);

    fsm16_muldiv u_muldiv (
        .clk    (clk),
        .rst_n  (rst),
        .load   (md_load),
        .is_mul (op_code == OP_MUL),
        .a      (a),
        .b      (b),
        .done   (md_done),
        .hi     (md_hi),
        .lo     (md_lo)
    );

    // Single-cycle ALU datapath on the operands latched at start.
    always_comb begin
        sh      = a_q[3:0];
        add_r   = {1'b0, b_q} + {1'b0, a_q} + {16'h0000, cin_q};
        sub_r   = {1'b0, b_q} - {1'b0, a_q} - {16'h0000, bin_q};
        cmp_r   = {1'b0, b_q} - {1'b0, a_q};
        inc_r   = {1'b0, b_q} + 17'd1;
        dec_r   = {1'b0, b_q} - 17'd1;
        lsl_w   = {16'h0000, b_q} << sh;
        lsr_w   = {b_q, 16'h0000} >> sh;
        rol_w   = {b_q, b_q} << sh;
        ror_w   = {b_q, b_q} >> sh;
        val     = result_q;
        val_c   = 1'b0;
        val_v   = 1'b0;
        wr_res  = 1'b1;
        wr_fl   = 1'b1;
        wr_cout = 1'b0;
        wr_bout = 1'b0;
        case (op_q)
            OP_ADD: begin
                val     = add_r[15:0];
                val_c   = add_r[16];
                val_v   = (b_q[15] == a_q[15]) && (add_r[15] != b_q[15]);
                wr_cout = 1'b1;
            end
            OP_SUB: begin
                val     = sub_r[15:0];
                val_c   = sub_r[16];
                val_v   = (b_q[15] != a_q[15]) && (sub_r[15] != b_q[15]);
                wr_bout = 1'b1;
            end
            OP_AND: val = b_q & a_q;
            OP_OR:  val = b_q | a_q;
            OP_XOR: val = b_q ^ a_q;
            OP_NOT: val = ~b_q;
            OP_LSL: begin
                val   = lsl_w[15:0];
                val_c = lsl_w[16];
            end
            OP_LSR: begin
                val   = lsr_w[31:16];
                val_c = lsr_w[15];
            end
            OP_ROL: begin
                val   = rol_w[31:16];
                val_c = (sh != 4'd0) && rol_w[16];
            end
            OP_ROR: begin
                val   = ror_w[15:0];
                val_c = (sh != 4'd0) && ror_w[15];
            end
            OP_CMP: begin
                val     = cmp_r[15:0];
                val_c   = cmp_r[16];
                val_v   = (b_q[15] != a_q[15]) && (cmp_r[15] != b_q[15]);
                wr_res  = 1'b0;
                wr_bout = 1'b1;
            end
            OP_TST: begin
                val    = b_q & a_q;
                wr_res = 1'b0;
            end
            OP_INC: begin
                val     = inc_r[15:0];
                val_c   = inc_r[16];
                val_v   = (b_q == 16'h7FFF);
                wr_cout = 1'b1;
            end
            OP_DEC: begin
                val     = dec_r[15:0];
                val_c   = dec_r[16];
                val_v   = (b_q == 16'h8000);
                wr_bout = 1'b1;
            end
            default: begin
                wr_res = 1'b0;
                wr_fl  = 1'b0;
            end
        endcase
    end

    // ALU sequencing: next state, result and flag updates.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cin_d    = cin_q;
        bin_d    = bin_q;
        result_d = result_q;
        rem_d    = rem_q;
        bout_d   = bout_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        cy_d     = cy_q;
        neg_d    = neg_q;
        zro_d    = zro_q;
        md_val   = md_lo;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op_code;
                    a_d     = a;
                    b_d     = b;
                    cin_d   = cin;
                    bin_d   = bin;
                    state_d = is_iter_op(op_code) ? ITER : EXEC;
                end else if (mov_enable) begin
                    result_d = a;
                    zro_d    = (a == 16'h0000);
                    neg_d    = a[15];
                end
            end
            EXEC: begin
                state_d = DONE;
                if (wr_res) result_d = val;
                if (wr_fl) begin
                    zro_d = (val == 16'h0000);
                    neg_d = val[15];
                    cy_d  = val_c;
                    ovf_d = val_v;
                end
                if (wr_cout) cout_d = val_c;
                if (wr_bout) bout_d = val_c;
            end
            ITER: begin
                if (md_done) begin
                    state_d = DONE;
                    cy_d    = 1'b0;
                    if (op_q == OP_MUL) begin
                        ovf_d = (md_hi != 16'h0000);
                    end else begin
                        rem_d = md_hi;
                        if (op_q == OP_MOD && a_q != 16'h0000) md_val = md_hi;
                        ovf_d = (a_q == 16'h0000);
                    end
                    result_d = md_val;
                    zro_d    = (md_val == 16'h0000);
                    neg_d    = md_val[15];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ALU state and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            op_q     <= 6'h00;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            cin_q    <= 1'b0;
            bin_q    <= 1'b0;
            result_q <= 16'h0000;
            rem_q    <= 16'h0000;
            bout_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cy_q     <= 1'b0;
            neg_q    <= 1'b0;
            zro_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cin_q    <= cin_d;
            bin_q    <= bin_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            bout_q   <= bout_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            cy_q     <= cy_d;
            neg_q    <= neg_d;
            zro_q    <= zro_d;
        end
    end

    // PC source select, highest priority first.
    always_comb begin
        pc_d = pc_q;
        if (save_address_from_instr_mem)     pc_d = address_from_instr_mem;
        else if (save_address_from_data_mem) pc_d = address_from_data_mem;
        else if (save_address_from_counter)  pc_d = address_from_counter_pc;
        else if (increm_pc)                  pc_d = pc_q + 16'd1;
    end

    // Stack pointer: saturates at 0 on push and at SP_TOP on pop.
    always_comb begin
        sp_d = sp_q;
        if (push && !pop && sp_q != 16'h0000) sp_d = sp_q - 16'd1;
        else if (pop && !push && sp_q != SP_TOP) sp_d = sp_q + 16'd1;
    end

    // PC and SP registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= PC_RESET;
            sp_q <= SP_TOP;
        end else begin
            pc_q <= pc_d;
            sp_q <= sp_d;
        end
    end

    assign result        = result_q;
    assign remainder     = rem_q;
    assign bout          = bout_q;
    assign cout          = cout_q;
    assign busy          = (state_q != IDLE);
    assign overflow_flag = ovf_q;
    assign carry_flag    = cy_q;
    assign negative_flag = neg_q;
    assign zero_flag     = zro_q;
    assign pc_out        = pc_q;
    assign sp_out        = sp_q;

endmodule

// File: tb/tb_fsm_16bit_exec.sv
// Directed bench for fsm_16bit_exec: ALU ops, busy timing,
// PC priority/wrap, SP saturation and async reset.
module tb_fsm_16bit_exec;

    logic        clk;
    logic        rst;
    logic        start;
    logic        mov_enable;
    logic [5:0]  op_code;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        cin;
    logic [15:0] result;
    logic [15:0] remainder;
    logic        bout;
    logic        cout;
    logic        busy;
    logic        overflow_flag;
    logic        carry_flag;
    logic        negative_flag;
    logic        zero_flag;
    logic        save_address_from_instr_mem;
    logic        save_address_from_data_mem;
    logic        save_address_from_counter;
    logic        increm_pc;
    logic [15:0] address_from_instr_mem;
    logic [15:0] address_from_data_mem;
    logic [15:0] address_from_counter_pc;
    logic [15:0] pc_out;
    logic        push;
    logic        pop;
    logic [15:0] sp_out;

    int n_chk;
    int n_fail;
    int cyc;

    fsm_16bit_exec dut (
        .clk                         (clk),
        .rst                         (rst),
        .start                       (start),
        .mov_enable                  (mov_enable),
        .op_code                     (op_code),
        .a                           (a),
        .b                           (b),
        .bin                         (bin),
        .cin                         (cin),
        .result                      (result),
        .remainder                   (remainder),
        .bout                        (bout),
        .cout                        (cout),
        .busy                        (busy),
        .overflow_flag               (overflow_flag),
        .carry_flag                  (carry_flag),
        .negative_flag               (negative_flag),
        .zero_flag                   (zero_flag),
        .save_address_from_instr_mem (save_address_from_instr_mem),
        .save_address_from_data_mem  (save_address_from_data_mem),
        .save_address_from_counter   (save_address_from_counter),
        .increm_pc                   (increm_pc),
        .address_from_instr_mem      (address_from_instr_mem),
        .address_from_data_mem       (address_from_data_mem),
        .address_from_counter_pc     (address_from_counter_pc),
        .pc_out                      (pc_out),
        .push                        (push),
        .pop                         (pop),
        .sp_out                      (sp_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue one ALU op and count cycles with busy high (bounded).
    task automatic run_op(input logic [5:0] op, input logic [15:0] av,
                          input logic [15:0] bv, input logic ci,
                          input logic bi, output int cycles);
        @(negedge clk);
        op_code = op;
        a       = av;
        b       = bv;
        cin     = ci;
        bin     = bi;
        start   = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cycles = 0;
        while (busy && cycles < 40) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b0;
        start = 1'b0;
        mov_enable = 1'b0;
        op_code = 6'h00;
        a = 16'h0000;
        b = 16'h0000;
        bin = 1'b0;
        cin = 1'b0;
        save_address_from_instr_mem = 1'b0;
        save_address_from_data_mem = 1'b0;
        save_address_from_counter = 1'b0;
        increm_pc = 1'b0;
        address_from_instr_mem = 16'h0000;
        address_from_data_mem = 16'h0000;
        address_from_counter_pc = 16'h0000;
        push = 1'b0;
        pop = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 16'h0000);
        chk("rst_rem", remainder, 16'h0000);
        chk("rst_zero", zero_flag, 0);
        chk("rst_pc", pc_out, 16'h0000);
        chk("rst_sp", sp_out, 16'h01FF);
        rst = 1'b1;

        run_op(6'h01, 16'h0001, 16'hFFFF, 1'b0, 1'b0, cyc);
        chk("add_cycles", cyc, 2);
        chk("add_result", result, 16'h0000);
        chk("add_cout", cout, 1);
        chk("add_carry", carry_flag, 1);
        chk("add_zero", zero_flag, 1);
        chk("add_ovf", overflow_flag, 0);

        run_op(6'h02, 16'h0005, 16'h0003, 1'b0, 1'b0, cyc);
        chk("sub_result", result, 16'hFFFE);
        chk("sub_bout", bout, 1);
        chk("sub_neg", negative_flag, 1);
        chk("sub_carry", carry_flag, 1);
        chk("sub_zero", zero_flag, 0);

        run_op(6'h0E, 16'h0005, 16'h0003, 1'b0, 1'b0, cyc);
        chk("cmp_result", result, 16'hFFFE);
        chk("cmp_neg", negative_flag, 1);
        chk("cmp_carry", carry_flag, 1);
        chk("cmp_zero", zero_flag, 0);
        chk("cmp_ovf", overflow_flag, 0);

        run_op(6'h03, 16'h0100, 16'h0100, 1'b0, 1'b0, cyc);
        chk("mul_cycles", cyc, 18);
        chk("mul_result", result, 16'h0000);
        chk("mul_ovf", overflow_flag, 1);
        chk("mul_zero", zero_flag, 1);

        run_op(6'h03, 16'h0007, 16'h0013, 1'b0, 1'b0, cyc);
        chk("mul2_result", result, 16'h0085);
        chk("mul2_ovf", overflow_flag, 0);

        run_op(6'h04, 16'h0005, 16'h0011, 1'b0, 1'b0, cyc);
        chk("div_cycles", cyc, 18);
        chk("div_result", result, 16'h0003);
        chk("div_rem", remainder, 16'h0002);
        chk("div_ovf", overflow_flag, 0);

        run_op(6'h05, 16'h0005, 16'h0011, 1'b0, 1'b0, cyc);
        chk("mod_result", result, 16'h0002);

        run_op(6'h04, 16'h0000, 16'h1234, 1'b0, 1'b0, cyc);
        chk("div0_cycles", cyc, 18);
        chk("div0_result", result, 16'hFFFF);
        chk("div0_rem", remainder, 16'h1234);
        chk("div0_ovf", overflow_flag, 1);

        run_op(6'h08, 16'h00FF, 16'h0F0F, 1'b0, 1'b0, cyc);
        chk("xor_result", result, 16'h0FF0);

        run_op(6'h0A, 16'h0001, 16'h8001, 1'b0, 1'b0, cyc);
        chk("lsl_result", result, 16'h0002);
        chk("lsl_carry", carry_flag, 1);

        run_op(6'h0D, 16'h0004, 16'h0001, 1'b0, 1'b0, cyc);
        chk("ror_result", result, 16'h1000);

        run_op(6'h10, 16'h0000, 16'h7FFF, 1'b0, 1'b0, cyc);
        chk("inc_result", result, 16'h8000);
        chk("inc_ovf", overflow_flag, 1);
        chk("inc_neg", negative_flag, 1);

        run_op(6'h3F, 16'h1111, 16'h2222, 1'b0, 1'b0, cyc);
        chk("nop_cycles", cyc, 2);
        chk("nop_result", result, 16'h8000);
        chk("nop_ovf", overflow_flag, 1);

        @(negedge clk);
        a = 16'h0000;
        mov_enable = 1'b1;
        @(negedge clk);
        mov_enable = 1'b0;
        chk("mov0_result", result, 16'h0000);
        chk("mov0_zero", zero_flag, 1);
        chk("mov0_busy", busy, 0);
        a = 16'h8001;
        mov_enable = 1'b1;
        @(negedge clk);
        mov_enable = 1'b0;
        chk("mov1_result", result, 16'h8001);
        chk("mov1_neg", negative_flag, 1);
        chk("mov1_zero", zero_flag, 0);

        increm_pc = 1'b1;
        repeat (3) @(negedge clk);
        increm_pc = 1'b0;
        chk("pc_inc3", pc_out, 16'h0003);
        address_from_instr_mem = 16'h0042;
        save_address_from_instr_mem = 1'b1;
        increm_pc = 1'b1;
        @(negedge clk);
        save_address_from_instr_mem = 1'b0;
        increm_pc = 1'b0;
        chk("pc_instr", pc_out, 16'h0042);
        address_from_data_mem = 16'h1111;
        address_from_counter_pc = 16'h2222;
        save_address_from_data_mem = 1'b1;
        save_address_from_counter = 1'b1;
        increm_pc = 1'b1;
        @(negedge clk);
        save_address_from_data_mem = 1'b0;
        increm_pc = 1'b0;
        chk("pc_data", pc_out, 16'h1111);
        address_from_counter_pc = 16'hFFFF;
        @(negedge clk);
        save_address_from_counter = 1'b0;
        chk("pc_cnt", pc_out, 16'hFFFF);
        increm_pc = 1'b1;
        @(negedge clk);
        increm_pc = 1'b0;
        chk("pc_wrap", pc_out, 16'h0000);
        @(negedge clk);
        chk("pc_hold", pc_out, 16'h0000);

        push = 1'b1;
        repeat (2) @(negedge clk);
        chk("sp_push2", sp_out, 16'h01FD);
        pop = 1'b1;
        @(negedge clk);
        chk("sp_both", sp_out, 16'h01FD);
        push = 1'b0;
        repeat (3) @(negedge clk);
        pop = 1'b0;
        chk("sp_pop3", sp_out, 16'h01FF);
        push = 1'b1;
        repeat (511) @(negedge clk);
        chk("sp_zero", sp_out, 16'h0000);
        @(negedge clk);
        push = 1'b0;
        chk("sp_floor", sp_out, 16'h0000);

        increm_pc = 1'b1;
        @(negedge clk);
        increm_pc = 1'b0;
        op_code = 6'h03;
        a = 16'h0003;
        b = 16'h0005;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_result", result, 16'h0000);
        chk("arst_pc", pc_out, 16'h0000);
        chk("arst_sp", sp_out, 16'h01FF);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fsm_16bit_exec.md
Name: fsm_16bit_exec

Overview:
- Execution core of the 16-bit general-purpose processor. It bundles three functions: a 16-bit multi-cycle ALU state machine, the program counter and the stack pointer.
- The control unit drives it. The ALU result feeds the accumulator, and the flags feed the branch decode.
- The PC addresses instruction memory. The SP addresses the return-address area of data memory.

Parameters:
- SP_TOP, 16'h01FF, SP reset value and upper pop limit.
- PC_RESET, 16'h0000, PC reset value.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: begin ALU op_code.
- mov_enable  in  1  one-cycle pulse: MOV, result<=a.
- op_code  in  6  ALU operation.
- a  in  16  immediate operand, zero-extended 9-bit.
- b  in  16  register operand.
- bin  in  1  borrow-in for SUB.
- cin  in  1  carry-in for ADD.
- result  out  16  registered ALU result.
- remainder  out  16  DIV/MOD remainder.
- bout  out  1  borrow-out.
- cout  out  1  carry-out.
- busy  out  1  ALU operation in progress.
- overflow_flag, carry_flag, negative_flag, zero_flag  out  1 each  status flags.
- save_address_from_instr_mem, save_address_from_data_mem, save_address_from_counter, increm_pc  in  1 each  PC load/increment controls.
- address_from_instr_mem, address_from_data_mem, address_from_counter_pc  in  16 each  PC load sources.
- pc_out  out  16  program counter.
- push, pop  in  1 each  stack pointer controls.
- sp_out  out  16  stack pointer.

Behaviour:
- Reset (rst=0, async): result, remainder, bout, cout, busy and all flags are 0; ALU state is IDLE; pc_out=PC_RESET; sp_out=SP_TOP.
- ALU states: IDLE -> EXEC (single-cycle ops) or ITER (MUL/DIV/MOD) -> DONE -> IDLE.
  - start is sampled in IDLE only, and is ignored while busy.
  - busy rises on the edge that samples start and stays high through DONE.
  - Single-cycle ops have latency 2: result is valid on the edge that enters DONE, busy falls the next edge.
  - MUL/DIV/MOD take 16 ITER cycles (shift-add / restoring division), so busy is high for 18 cycles.
- Opcodes (result = b op a):
  - 01 ADD: {cout,result}=b+a+cin.
  - 02 SUB: b-a-bin; bout=borrow.
  - 03 MUL: low 16 bits of product.
  - 04 DIV: quotient; remainder=b%a.
  - 05 MOD: result=b%a.
  - 06 AND; 07 OR; 08 XOR; 09 NOT (~b).
  - 0A LSL b<<a[3:0]; 0B LSR b>>a[3:0]; 0C ROL; 0D ROR (rotate by a[3:0]).
  - 0E CMP: flags of b-a, result unchanged.
  - 0F TST: flags of b&a, result unchanged.
  - 10 INC b+1; 11 DEC b-1.
  - Other codes: NOP, result unchanged, flags unchanged, still completes with busy protocol.
- MOV: mov_enable in IDLE sets result<=a on the next edge, updates zero/negative only, busy stays 0. If start and mov_enable are both high, start wins.
- Flags update only on completion (DONE entry, or MOV):
  - zero = (value==0); negative = value[15].
  - carry = cout for ADD/INC, bout for SUB/CMP/DEC, last bit shifted out for shifts, 0 otherwise.
  - overflow = signed overflow for ADD/SUB/CMP/INC/DEC; for MUL, product[31:16]!=0; 0 otherwise.
- Divide by zero (DIV/MOD with a=0): result=16'hFFFF, remainder=b, overflow_flag=1, same 18-cycle latency.
- PC priority per edge: save_address_from_instr_mem > save_address_from_data_mem > save_address_from_counter > increm_pc (pc+1, wraps FFFF->0000). With no control high, PC holds.
- SP (stack grows downward):
  - push alone: sp-1; ignored at 0.
  - pop alone: sp+1; ignored at SP_TOP.
  - push and pop together: SP holds.
- Reset mid-operation aborts the ALU immediately to reset values.

Decomposition:
- Shared package fsm16_pkg holds the opcode localparams (OP_ADD..OP_MOV), the ALU state enum (IDLE, EXEC, ITER, DONE), and constants SP_TOP and PC_RESET.
- One natural sub-module, fsm16_muldiv: the 16-cycle iterative multiplier/divider.
- PC and SP are small always blocks in the top.

Test Plan:
- Reset asserted mid-MUL -> busy=0, result=0, pc_out=0000, sp_out=01FF immediately, before the next clk edge.
- ADD a=0x0001, b=0xFFFF, cin=0 -> result=0x0000, cout=1, carry=1, zero=1, overflow=0; busy high for exactly 2 cycles.
- SUB a=5, b=3, bin=0 -> result=0xFFFE, bout=1, negative=1. CMP with the same operands -> flags identical, result unchanged.
- MUL a=0x0100, b=0x0100 -> result=0x0000, overflow=1, busy 18 cycles. DIV b=17, a=5 -> result=3, remainder=2. DIV by 0 -> result=FFFF, overflow=1.
- PC: increm_pc x3 from reset -> 0003; instr_mem=0x0042 and increm_pc together -> 0042; increm at FFFF -> 0000.
- SP: push x2 -> 01FD; push+pop together -> 01FD; pop x3 -> 01FF (saturates at the top); push from 0 -> 0.
